// File: rtl/regfile_dump_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_if
//   Bundle of every non-clock/reset signal of the register-file dump engine.
//
//   Control:
//     start       -> engine  begin a dump (sampled only while idle)
//     busy        <- engine  dump in progress
//     done        <- engine  one-cycle pulse after the final word handshake
//   Register-file read port (engine is the requester):
//     rf_addr     <- engine  read address, equals the current index
//     rf_data     -> engine  combinational read data
//   Output stream (valid/ready):
//     dump_valid  <- engine  word valid
//     dump_ready  -> engine  sink accepts the word
//     dump_addr   <- engine  register index of the word
//     dump_data   <- engine  captured register value (or checksum)
//     dump_last   <- engine  final word of the dump
//
//   master : the dump engine
//   slave  : the environment (register file + stream sink + controller)
// ---------------------------------------------------------------------------
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    input  start,
    input  rf_data,
    input  dump_ready,
    output busy,
    output done,
    output rf_addr,
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_last
  );

  modport slave (
    output start,
    output rf_data,
    output dump_ready,
    input  busy,
    input  done,
    input  rf_addr,
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_last
  );
endinterface

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//   Read-out engine that walks registers 0..NUM_REGS-1 of a register file
//   through a single combinational read port and streams each
//   (index, value) pair on a valid/ready interface.
//
//   Ports:
//     clk  - system clock, all state changes on posedge
//     rst  - asynchronous, active-high reset
//     bus  - regfile_dump_if.master: start/busy/done control, register-file
//            read port (rf_addr/rf_data) and the dump stream
//            (dump_valid/ready/addr/data/last)
//
//   Optional feature (macro REGFILE_DUMP_CHECKSUM_EN):
//     When defined, an XOR accumulator of all captured words is sent as an
//     extra final word (dump_addr=0, dump_last=1) after register NUM_REGS-1,
//     and register words never carry dump_last.
//
//   Per-word sequence: LOAD drives rf_addr=index and captures rf_data on the
//   next posedge, SEND holds the word until the handshake. With ready held
//   high a word is produced every two cycles.
// ---------------------------------------------------------------------------
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  regfile_dump_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3,
    S_CKSUM = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  logic              handshake;
  logic              at_last_idx;

  assign handshake   = valid_q & bus.dump_ready;
  assign at_last_idx = (index_q == LAST_IDX);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    busy_d  = busy_q;
    done_d  = 1'b0;          // done is a single-cycle pulse
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d   = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        index_d = '0;
        if (bus.start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end

      S_LOAD: begin
        // rf_addr has been presenting index_q for this whole cycle, so the
        // read data at this edge belongs to the current index.
        state_d = S_SEND;
        valid_d = 1'b1;
        addr_d  = index_q;
        data_d  = bus.rf_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        last_d  = 1'b0;
        acc_d   = acc_q ^ bus.rf_data;
`else
        last_d  = at_last_idx;
`endif
      end

      S_SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (at_last_idx) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // Present the checksum word straight away; the accumulator
            // already includes the final register captured in LOAD.
            state_d = S_CKSUM;
            valid_d = 1'b1;
            addr_d  = '0;
            data_d  = acc_q;
            last_d  = 1'b1;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            // Index stops at the final register; it is only advanced here.
            index_d = index_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CKSUM: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
`endif

      S_DONE: begin
        // start is deliberately not looked at here; a request must be
        // presented again once the engine is back in IDLE.
        busy_d  = 1'b0;
        index_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        index_d = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs are driven straight from registers
  // -------------------------------------------------------------------------
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rf_addr    = index_q;
  assign bus.dump_valid = valid_q;
  assign bus.dump_addr  = addr_q;
  assign bus.dump_data  = data_q;
  assign bus.dump_last  = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump
//   Directed bench for regfile_dump. The register-file model holds
//   reg[i] = i+1 and answers rf_addr combinationally. Inputs are driven and
//   outputs sampled on the falling edge.
//   Cycle counting: "k" is the number of rising edges after the edge that
//   accepted start (word i appears after edge 2i+1; done after edge 64,
//   i.e. the 65th edge counting the accepting edge).
// ---------------------------------------------------------------------------
module tb_regfile_dump;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CKSUM = 1;
`else
  localparam int CKSUM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign bus.rf_data = regs[bus.rf_addr];

  regfile_dump #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int tr     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All outputs at their reset/idle values.
  task automatic chk_idle(input string tag);
    chk(tag, {18'd0, bus.busy, bus.done, bus.dump_valid, bus.dump_last,
              bus.rf_addr, bus.dump_addr, bus.dump_data}, 64'd0);
  endtask

  // Pulse start for one edge; leaves us at the falling edge after acceptance.
  task automatic do_start(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_load_valid"}, 64'(bus.dump_valid), 64'd0);
    chk({tag, "_rf_addr0"}, 64'(bus.rf_addr), 64'd0);
  endtask

  // Wait (bounded) for the next valid word and check its contents.
  task automatic expect_word(input int i, input bit timed);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bus.dump_valid) seen = 1'b1;
    end
    chk($sformatf("w%0d_seen", i), 64'(seen), 64'd1);
    if (seen) begin
      chk($sformatf("w%0d_addr", i), 64'(bus.dump_addr), 64'(i));
      chk($sformatf("w%0d_data", i), 64'(bus.dump_data), 64'(i + 1));
      chk($sformatf("w%0d_last", i), 64'(bus.dump_last),
          64'((CKSUM == 0) && (i == NUM_REGS - 1)));
      chk($sformatf("w%0d_rf_addr", i), 64'(bus.rf_addr), 64'(i));
      chk($sformatf("w%0d_busy", i), 64'(bus.busy), 64'd1);
      if (timed) chk($sformatf("w%0d_time", i), 64'(cyc - t0), 64'(2 * i + 1));
    end
  endtask

  // Optional checksum word, then the done pulse.
  task automatic finish_dump(input string tag, input bit timed, input bit poke_exit);
    bit seen;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.dump_valid) seen = 1'b1;
    end
    chk({tag, "_ck_seen"}, 64'(seen), 64'd1);
    chk({tag, "_ck_data"}, 64'(bus.dump_data), 64'h20);
    chk({tag, "_ck_addr"}, 64'(bus.dump_addr), 64'd0);
    chk({tag, "_ck_last"}, 64'(bus.dump_last), 64'd1);
`endif
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else chk({tag, "_no_early_done"}, 64'(bus.busy), 64'd1);
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (timed) chk({tag, "_done_time"}, 64'(cyc - t0), 64'(2 * NUM_REGS + CKSUM));
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd1);
    chk({tag, "_valid_in_done"}, 64'(bus.dump_valid), 64'd0);
    if (poke_exit) bus.start = 1'b1;   // high across the DONE exit edge
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i + 1);

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset_held");
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk_idle($sformatf("idle_%0d", n));
    end

    // Full dump, ready held high
    do_start("full");
    for (int i = 0; i < NUM_REGS; i++) expect_word(i, 1'b1);
    finish_dump("full", 1'b1, 1'b0);

    // Backpressure on word 7
    do_start("bp");
    for (int i = 0; i < 8; i++) expect_word(i, 1'b1);
    bus.dump_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", s), 64'(bus.dump_valid), 64'd1);
      chk($sformatf("bp_hold%0d_data", s), 64'(bus.dump_data), 64'd8);
      chk($sformatf("bp_hold%0d_addr", s), 64'(bus.dump_addr), 64'd7);
    end
    bus.dump_ready = 1'b1;
    tr = cyc;
    expect_word(8, 1'b0);
    chk("bp_word8_gap", 64'(cyc - tr), 64'd2);
    for (int i = 9; i < NUM_REGS; i++) expect_word(i, 1'b0);
    finish_dump("bp", 1'b0, 1'b0);

    // start while busy (at word 10) and start during DONE exit
    do_start("sb");
    for (int i = 0; i < 11; i++) expect_word(i, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 11; i < NUM_REGS; i++) expect_word(i, 1'b1);
    finish_dump("sb", 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("sb_quiet%0d", n),
          64'({bus.busy, bus.dump_valid, bus.done}), 64'd0);
    end

    // Reset in the middle of word 15
    do_start("rm");
    for (int i = 0; i < 16; i++) expect_word(i, 1'b1);
    bus.dump_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_idle("rm_async_reset");
    @(negedge clk);
    chk_idle("rm_reset_held");
    rst = 1'b0;
    bus.dump_ready = 1'b1;
    @(negedge clk);
    chk_idle("rm_idle_after");
    do_start("rm2");
    for (int i = 0; i < NUM_REGS; i++) expect_word(i, 1'b1);
    finish_dump("rm2", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
